// File: rtl/pipe_credit_pkg.sv
// Shared types and helpers for the credit-managed pipeline receive block.
package pipe_credit_pkg;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic ovf;
      logic unexp;
   } err_flags_t;

endpackage

// File: rtl/sync_fifo_cnt.sv
// W x DEPTH synchronous FIFO with occupancy count; DEPTH need not be a power of 2.
module sync_fifo_cnt
   import pipe_credit_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // A pop on an empty FIFO is ignored; a push while full only lands if the head leaves.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/pipe_credit_rx.sv
// Receive end of a non-stallable pipe: credit-gated issue, result FIFO, valid/ready output.
module pipe_credit_rx
   import pipe_credit_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int CW    = cnt_width(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue_req,
   output logic          issue_gnt,
   input  logic          ret_valid,
   input  logic [W-1:0]  ret_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [CW-1:0] credits,
   output logic [CW-1:0] in_flight,
   output logic          err_ovf,
   output logic          err_unexp
);

   logic          issue;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] occupancy;
   err_flags_t    err_q;

   // Grant depends only on the registered credit count, keeping out_ready off this path.
   assign issue_gnt = (credits != '0);
   assign issue     = issue_req && issue_gnt;
   assign out_valid = !fifo_empty;
   assign pop       = out_valid && out_ready;
   assign err_ovf   = err_q.ovf;
   assign err_unexp = err_q.unexp;

   sync_fifo_cnt #(
      .W     (W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ret_valid),
      .push_data (ret_data),
      .pop       (pop),
      .head_data (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (occupancy)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits   <= CW'(DEPTH);
         in_flight <= '0;
         err_q     <= '0;
      end else begin
         if (issue && !pop)      credits <= credits - CW'(1);
         else if (pop && !issue) credits <= credits + CW'(1);

         // An unexpected return leaves the counter pinned at zero.
         if (issue && !ret_valid)                            in_flight <= in_flight + CW'(1);
         else if (!issue && ret_valid && in_flight != '0)    in_flight <= in_flight - CW'(1);

         if (ret_valid && fifo_full && !pop) err_q.ovf   <= 1'b1;
         if (ret_valid && in_flight == '0)   err_q.unexp <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && err_q == '0)
         assert (int'(credits) + int'(occupancy) + int'(in_flight) == DEPTH)
            else $error("credit invariant broken");
   end

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Directed bench: DEPTH=4 with a 3-cycle pipe model, DEPTH=1 overflow misuse, DEPTH=3 wrap and reset.
module tb_pipe_credit_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DEPTH = 4 instance, fed by a 3-stage pipe model plus a manual return port
   logic       rst4_n, issue_req4, issue_gnt4, ret_valid4, out_valid4, out_ready4;
   logic       err_ovf4, err_unexp4, man_v4;
   logic [7:0] ret_data4, out_data4, man_d4;
   logic [2:0] credits4, in_flight4;

   logic       s0v, s1v, s2v;
   logic [7:0] s0d, s1d, s2d, fire_cnt;

   // DEPTH = 1 instance
   logic       rst1_n, issue_req1, issue_gnt1, ret_valid1, out_valid1, out_ready1;
   logic       err_ovf1, err_unexp1;
   logic [7:0] ret_data1, out_data1;
   logic [0:0] credits1, in_flight1;

   // DEPTH = 3 instance
   logic       rst3_n, issue_req3, issue_gnt3, ret_valid3, out_valid3, out_ready3;
   logic       err_ovf3, err_unexp3;
   logic [7:0] ret_data3, out_data3;
   logic [1:0] credits3, in_flight3;

   int         occ_m = 0;
   logic       inv_en = 1'b0;
   logic       pop_chk_en = 1'b0;
   logic [7:0] exp_pop = 8'h11;

   pipe_credit_rx #(.W(8), .DEPTH(4)) u4 (
      .clk(clk), .rst_n(rst4_n), .issue_req(issue_req4), .issue_gnt(issue_gnt4),
      .ret_valid(ret_valid4), .ret_data(ret_data4), .out_valid(out_valid4),
      .out_ready(out_ready4), .out_data(out_data4), .credits(credits4),
      .in_flight(in_flight4), .err_ovf(err_ovf4), .err_unexp(err_unexp4)
   );

   pipe_credit_rx #(.W(8), .DEPTH(1)) u1 (
      .clk(clk), .rst_n(rst1_n), .issue_req(issue_req1), .issue_gnt(issue_gnt1),
      .ret_valid(ret_valid1), .ret_data(ret_data1), .out_valid(out_valid1),
      .out_ready(out_ready1), .out_data(out_data1), .credits(credits1),
      .in_flight(in_flight1), .err_ovf(err_ovf1), .err_unexp(err_unexp1)
   );

   pipe_credit_rx #(.W(8), .DEPTH(3)) u3 (
      .clk(clk), .rst_n(rst3_n), .issue_req(issue_req3), .issue_gnt(issue_gnt3),
      .ret_valid(ret_valid3), .ret_data(ret_data3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_data(out_data3), .credits(credits3),
      .in_flight(in_flight3), .err_ovf(err_ovf3), .err_unexp(err_unexp3)
   );

   // Fixed 3-cycle pipe: item k issued carries 0x11 + k
   always @(posedge clk or negedge rst4_n) begin
      if (!rst4_n) begin
         s0v <= 1'b0; s1v <= 1'b0; s2v <= 1'b0;
         s0d <= '0;   s1d <= '0;   s2d <= '0;
         fire_cnt <= '0;
      end else begin
         s0v <= issue_req4 && issue_gnt4;
         s0d <= 8'h11 + fire_cnt;
         if (issue_req4 && issue_gnt4) fire_cnt <= fire_cnt + 8'd1;
         s1v <= s0v; s1d <= s0d;
         s2v <= s1v; s2d <= s1d;
      end
   end

   assign ret_valid4 = s2v | man_v4;
   assign ret_data4  = s2v ? s2d : man_d4;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      logic push, pop;
      pop  = out_valid4 && out_ready4;
      push = ret_valid4 && (occ_m < 4 || pop);
      if (pop_chk_en && pop) begin
         chk("pop_order", 32'(out_data4), 32'(exp_pop));
         exp_pop = exp_pop + 8'd1;
      end
      @(posedge clk);
      occ_m = occ_m + int'(push) - int'(pop);
      #1;
      if (inv_en) chk("invariant", int'(credits4) + occ_m + int'(in_flight4), 4);
   endtask

   initial begin
      rst4_n = 1'b0; rst1_n = 1'b0; rst3_n = 1'b0;
      issue_req4 = 0; out_ready4 = 0; man_v4 = 0; man_d4 = '0;
      issue_req1 = 0; out_ready1 = 0; ret_valid1 = 0; ret_data1 = '0;
      issue_req3 = 0; out_ready3 = 0; ret_valid3 = 0; ret_data3 = '0;
      repeat (2) step();
      rst4_n = 1'b1; rst1_n = 1'b1; rst3_n = 1'b1;
      repeat (5) step();

      chk("rst_credits", credits4, 4);
      chk("rst_gnt", issue_gnt4, 1);
      chk("rst_out_valid", out_valid4, 0);
      chk("rst_out_data", out_data4, 0);
      chk("rst_in_flight", in_flight4, 0);
      chk("rst_err_ovf", err_ovf4, 0);
      chk("rst_err_unexp", err_unexp4, 0);
      chk("rst_credits_d1", credits1, 1);
      chk("rst_credits_d3", credits3, 3);

      // Fill: issue continuously with the consumer stalled
      inv_en = 1'b1;
      issue_req4 = 1'b1;
      repeat (3) step();
      chk("fill_credits_3rd", credits4, 1);
      chk("fill_gnt_3rd", issue_gnt4, 1);
      step();
      chk("fill_credits_4th", credits4, 0);
      chk("fill_gnt_4th", issue_gnt4, 0);
      chk("fill_in_flight_4th", in_flight4, 3);
      chk("fill_first_ret", out_data4, 8'h11);
      repeat (3) step();
      chk("full_out_valid", out_valid4, 1);
      chk("full_head", out_data4, 8'h11);
      chk("full_in_flight", in_flight4, 0);
      chk("full_credits", credits4, 0);
      chk("full_no_ovf", err_ovf4, 0);

      // Drain while issuing: strict order and credit return one cycle after each pop
      pop_chk_en = 1'b1;
      out_ready4 = 1'b1;
      step();
      chk("pop_credit_next", credits4, 1);
      chk("pop_gnt_next", issue_gnt4, 1);
      chk("pop_head_next", out_data4, 8'h12);
      repeat (19) step();
      issue_req4 = 1'b0;
      repeat (12) step();
      chk("drain_credits", credits4, 4);
      chk("drain_in_flight", in_flight4, 0);
      chk("drain_out_valid", out_valid4, 0);
      chk("drain_all_popped", exp_pop, 8'h11 + fire_cnt);

      // Unexpected return: flagged, but data still enqueued
      inv_en = 1'b0;
      pop_chk_en = 1'b0;
      out_ready4 = 1'b0;
      man_v4 = 1'b1; man_d4 = 8'hA5;
      step();
      man_v4 = 1'b0;
      chk("unexp_flag", err_unexp4, 1);
      chk("unexp_data", out_data4, 8'hA5);
      chk("unexp_valid", out_valid4, 1);
      chk("unexp_in_flight", in_flight4, 0);
      chk("unexp_no_ovf", err_ovf4, 0);
      repeat (2) step();
      chk("unexp_sticky", err_unexp4, 1);

      // DEPTH=1: full FIFO with zero credits, extra return overflows
      issue_req1 = 1'b1;
      step();
      issue_req1 = 1'b0;
      chk("d1_credits", credits1, 0);
      chk("d1_gnt", issue_gnt1, 0);
      ret_valid1 = 1'b1; ret_data1 = 8'h3C;
      step();
      chk("d1_head", out_data1, 8'h3C);
      chk("d1_no_ovf", err_ovf1, 0);
      ret_data1 = 8'h77;
      step();
      ret_valid1 = 1'b0;
      chk("d1_ovf", err_ovf1, 1);
      chk("d1_head_kept", out_data1, 8'h3C);
      step();
      chk("d1_ovf_sticky", err_ovf1, 1);
      chk("d1_head_still", out_data1, 8'h3C);

      // DEPTH=3: wrap both pointers past 2, then reset mid-burst
      issue_req3 = 1'b1;
      repeat (3) step();
      issue_req3 = 1'b0;
      chk("d3_credits0", credits3, 0);
      chk("d3_in_flight3", in_flight3, 3);
      for (int i = 0; i < 3; i++) begin
         ret_valid3 = 1'b1; ret_data3 = 8'h31 + 8'(i);
         step();
      end
      ret_valid3 = 1'b0;
      chk("d3_head_31", out_data3, 8'h31);
      out_ready3 = 1'b1;
      repeat (2) step();
      out_ready3 = 1'b0;
      chk("d3_head_33", out_data3, 8'h33);
      chk("d3_credits2", credits3, 2);
      issue_req3 = 1'b1;
      step();
      ret_valid3 = 1'b1; ret_data3 = 8'h34;
      step();
      ret_valid3 = 1'b0; issue_req3 = 1'b0;
      out_ready3 = 1'b1;
      step();
      out_ready3 = 1'b0;
      chk("d3_wrap_head", out_data3, 8'h34);
      chk("d3_wrap_credits", credits3, 1);
      chk("d3_no_err", {err_ovf3, err_unexp3}, 0);
      issue_req3 = 1'b1;
      step();
      rst3_n = 1'b0;
      #1;
      chk("d3_rst_credits", credits3, 3);
      chk("d3_rst_valid", out_valid3, 0);
      chk("d3_rst_in_flight", in_flight3, 0);
      step();
      issue_req3 = 1'b0;
      rst3_n = 1'b1;
      step();
      chk("d3_post_credits", credits3, 3);
      chk("d3_post_valid", out_valid3, 0);

      // DEPTH=4 reset mid-burst with occupancy 2 and in_flight 2
      rst4_n = 1'b0;
      occ_m = 0;
      step();
      rst4_n = 1'b1;
      chk("r4_err_clear", {err_ovf4, err_unexp4}, 0);
      inv_en = 1'b1;
      issue_req4 = 1'b1;
      repeat (5) step();
      chk("r4_in_flight2", in_flight4, 2);
      chk("r4_credits0", credits4, 0);
      chk("r4_head", out_data4, 8'h11);
      inv_en = 1'b0;
      rst4_n = 1'b0;
      occ_m = 0;
      #1;
      chk("r4_rst_credits", credits4, 4);
      chk("r4_rst_in_flight", in_flight4, 0);
      chk("r4_rst_valid", out_valid4, 0);
      chk("r4_rst_data", out_data4, 0);
      chk("r4_rst_gnt", issue_gnt4, 1);
      step();
      issue_req4 = 1'b0;
      rst4_n = 1'b1;
      repeat (4) step();
      chk("r4_post_credits", credits4, 4);
      chk("r4_post_in_flight", in_flight4, 0);
      chk("r4_post_unexp", err_unexp4, 0);
      chk("r4_post_valid", out_valid4, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_credit_rx.md
Name: pipe_credit_rx

Overview:
- Receive end of a fixed-latency, non-stallable pipeline, such as a chain of generic delay stages with no backpressure.
- Upstream issues into the pipe only when this block grants a credit.
- Results leaving the pipe are always accepted into an internal FIFO and presented to a consumer over valid/ready.
- Credits guarantee the FIFO can never overflow, whatever the pipe latency or consumer stalls.

Parameters:
- W, 8, data width of returned results.
- DEPTH, 4, FIFO entries and total credits (legal range 1..256).
- CW, $clog2(DEPTH+1), width of the credit, occupancy and in-flight counters (derived, do not override).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_req  in  1  upstream wants to inject one item into the pipe.
- issue_gnt  out  1  a credit is available; an issue occurs when issue_req && issue_gnt.
- ret_valid  in  1  pipe output carries a result this cycle.
- ret_data  in  W  pipe output data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head; a pop occurs when out_valid && out_ready.
- out_data  out  W  FIFO head data.
- credits  out  CW  free credits remaining.
- in_flight  out  CW  items issued but not yet returned.
- err_ovf  out  1  sticky: return arrived while FIFO full with no pop.
- err_unexp  out  1  sticky: return arrived while in_flight == 0.

Behaviour:
- Asynchronous reset values:
  - credits = DEPTH; in_flight = 0; FIFO empty; pointers = 0.
  - out_valid = 0; out_data = 0 (memory need not be reset; out_data is masked to 0 while empty).
  - err_ovf = 0; err_unexp = 0; issue_gnt = 1.
- Grant:
  - issue_gnt = (credits != 0), decoded from the registered count only.
  - No combinational path from out_ready or issue_req to issue_gnt.
- Credit counter:
  - issue alone: -1.
  - pop alone: +1.
  - issue and pop in the same cycle: unchanged.
  - Never underflows, because issue requires a grant.
- in_flight counter:
  - +1 on issue, -1 on a return.
  - Issue and return in the same cycle: unchanged.
  - A return while in_flight == 0 sets err_unexp; the counter holds at 0 but the data is still written if space exists.
- FIFO:
  - ret_valid writes ret_data at wr_ptr unconditionally when not full, or when full and a pop occurs in the same cycle.
  - Full, no pop, ret_valid: data dropped, err_ovf set, pointers unchanged.
  - Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of 2).
  - Occupancy counter 0..DEPTH.
  - Simultaneous push and pop on an empty FIFO: only the push applies, since out_valid was 0.
- Latency:
  - A return written in cycle t gives out_valid = 1 and out_data = that value from cycle t+1. There is no same-cycle bypass.
  - A pop in cycle t frees its credit, visible on credits and issue_gnt from t+1.
- Ordering: strict FIFO; out_data follows return order.
- Invariant for verification assertions: credits + occupancy + in_flight == DEPTH whenever neither error flag has ever been set.
- Error flags: sticky until reset; no effect on normal operation.
- Reset mid-operation: all state returns to reset values immediately. Items still in the external pipe that return after reset raise err_unexp. The integrator must reset the pipe and this block together.

Decomposition:
- Shared package pipe_credit_pkg:
  - Function returning the counter width for a given DEPTH.
  - Typedef for the error-flag struct {ovf, unexp}.
- One natural sub-module, sync_fifo_cnt: a W x DEPTH synchronous FIFO with occupancy output, full/empty, and non-power-of-2 pointer wrap.
- The credit and in-flight counters live in the top module.

Test Plan:
- Reset, then idle 5 cycles -> credits = 4, issue_gnt = 1, out_valid = 0, in_flight = 0, both error flags 0.
- issue_req held high with out_ready = 0, returns 3 cycles after each issue, data 0x11..0x14:
  - issue_gnt drops after the 4th issue; credits = 0.
  - FIFO fills to 4; out_data = 0x11; no err_ovf.
- From the full state, hold out_ready = 1 and issue_req = 1:
  - Pops yield 0x11, 0x12, 0x13, 0x14 in order.
  - Each pop's credit appears next cycle.
  - Steady state reaches one issue per cycle, with the invariant holding every cycle.
- Full FIFO and credits forced to 0 via DEPTH = 1 misuse; drive ret_valid with no pop -> err_ovf = 1 and stays 1; head data unchanged.
- ret_valid with in_flight = 0 -> err_unexp = 1; data 0xA5 still appears on out_data the next cycle.
- Assert rst_n mid-burst with occupancy 2 and in_flight 2 -> next cycle credits = 4, out_valid = 0, counters 0. Run with DEPTH = 3 to cover pointer wrap at 2 -> 0.
